dw_pw_layer_sched: RTL and testbench
====================================

Name: dw_pw_layer_sched

Overview:
- Sequencing controller for one depthwise-3x3 + pointwise-1x1 layer pair.
- Depthwise phase, channel by channel:
  - triggers the weight and bias/scale fetches;
  - runs the sliding-window/conv33/relu stream;
  - generates write addresses for the intermediate feature-map buffer.
- Pointwise phase, per output channel:
  - generates read addresses into that buffer (input channel fastest, feeding the adder tree);
  - counts accumulated results and generates output write addresses.
- Sits between the layer-level start/done handshake and the conv_dw_pw datapath.

Parameters:
- LAYER_DW_NUM, 1, layer index driven on ld_layer in DW phase
- LAYER_PW_NUM, 2, layer index driven on ld_layer in PW phase
- DW_CH, 16, depthwise channels (in = out)
- DW_OUT_HW, 64, depthwise output height = width (also PW spatial size)
- PW_IN_CH, 16, pointwise input channels (must equal DW_CH)
- PW_OUT_CH, 32, pointwise output channels
- CH_W, 10, channel index width
- HW_W, 7, row/column index width
- LAYER_W, 5, layer index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  layer start pulse
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- ld_start  out  1  one-cycle pulse to weight_mem and bias_scale_mem
- ld_layer  out  LAYER_W  layer index for the load
- ld_in_ch  out  CH_W  input channel for the load
- ld_out_ch  out  CH_W  output channel for the load (also bias/scale ch_idx)
- ld_done  in  1  pulse: weights and bias/scale for the current load are in place
- dw_run  out  1  enables the depthwise stream
- dw_res_valid  in  1  relu33 output valid
- dw_res_ready  out  1  ready to relu33
- fmw_en  out  1  intermediate buffer write enable
- fmw_ch  out  CH_W  intermediate buffer write channel
- fmw_h  out  HW_W  intermediate buffer write row
- fmw_w  out  HW_W  intermediate buffer write column
- pw_rd_valid  out  1  intermediate read request valid
- pw_rd_ready  in  1  intermediate read request ready
- pw_rd_ch  out  CH_W  read channel (= adder in_index)
- pw_rd_h  out  HW_W  read row
- pw_rd_w  out  HW_W  read column
- pw_res_valid  in  1  adder/relu11 result valid
- pw_res_ready  out  1  ready to adder/relu11
- pw_wr_en  out  1  output write enable
- pw_wr_ch  out  CH_W  output write channel
- pw_wr_h  out  HW_W  output write row
- pw_wr_w  out  HW_W  output write column

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous, active-high.
- Reset: state IDLE, all counters 0, every output 0.
- States: IDLE, DW_LOAD, DW_WAIT, DW_RUN, PW_LOAD, PW_WAIT, PW_RUN, FINISH.
- IDLE:
  - start=1 -> DW_LOAD with c=0.
  - start while busy is ignored.
- DW_LOAD:
  - ld_start=1 for exactly one cycle; ld_layer=LAYER_DW_NUM, ld_in_ch=ld_out_ch=c.
  - Next cycle -> DW_WAIT.
- DW_WAIT:
  - Wait for ld_done.
  - ld_done arriving in the same cycle as ld_start (DW_LOAD) is also accepted and goes directly to DW_RUN.
- DW_RUN:
  - dw_run=1, dw_res_ready=1.
  - Each beat (valid&ready): fmw_en=1 combinationally with fmw_ch=c, fmw_h=h, fmw_w=w; then w++.
  - w wraps at DW_OUT_HW-1 -> w=0, h++.
  - On the beat with h=w=DW_OUT_HW-1:
    - c<DW_CH-1 -> c++, DW_LOAD.
    - Otherwise -> PW_LOAD with oc=0.
  - dw_run drops the cycle after the last beat.
- PW_LOAD / PW_WAIT: as DW, with ld_layer=LAYER_PW_NUM, ld_in_ch=0, ld_out_ch=oc.
- PW_RUN, read side:
  - pw_rd_valid=1 until all DW_OUT_HW²·PW_IN_CH requests are issued.
  - Address order: ic fastest, then w, then h.
  - Address advances only on pw_rd_valid&pw_rd_ready; held stable while stalled.
- PW_RUN, result side:
  - pw_res_ready=1.
  - Each result beat writes pw_wr_ch=oc at the result (h,w) counters, which advance row-major.
  - After the last of DW_OUT_HW² results:
    - oc<PW_OUT_CH-1 -> oc++, PW_LOAD.
    - Otherwise -> FINISH.
  - A result arriving while requests are still outstanding is legal.
  - A result and a read in the same cycle both advance.
- FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Unexpected inputs:
  - dw_res_valid or pw_res_valid outside its RUN state: ready=0, ignored.
  - ld_done outside the WAIT/LOAD states: ignored.
- rst mid-operation: next cycle IDLE, counters cleared, no done.
- Counters are unsigned; widths must cover DW_OUT_HW-1 and the channel maxima (elaboration-time check).

Optional Feature:
- Macro: DW_PW_SCHED_PERF_EN.
- When defined:
  - Adds output stall_cnt [31:0].
  - Counts cycles in PW_RUN with pw_rd_valid&!pw_rd_ready, plus cycles in DW_WAIT/PW_WAIT.
  - Cleared on accepted start, saturates at max, holds after done.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - state enum;
  - CH_W/HW_W/LAYER_W defaults;
  - LOAD_PULSE_CYCLES=1 constant.
- One sub-module, sched_hw_counter: a reusable (ch,h,w) nested counter with enable, configurable channel-fastest or channel-fixed order, and a last flag.
- Instantiate it three times: DW write, PW read, PW result.

Test Plan (DW_CH=2, DW_OUT_HW=4, PW_IN_CH=2, PW_OUT_CH=2):
- start, ld_done 2 cycles after each ld_start, continuous valids -> expected sequence:
  - ld_start pulses ld_out_ch 0,1 (layer 1), then 0,1 (layer 2);
  - 32 fmw_en writes, ch0 (0,0)…(3,3), then ch1;
  - 64 reads, order ch0,ch1 per pixel;
  - 32 pw_wr_en;
  - single done; busy low after.
- pw_rd_ready toggling 1-0 -> read address held during low cycles; request count still 32 per oc; the macro-enabled build shows stall_cnt = stall cycles.
- ld_done same cycle as ld_start -> no DW_WAIT cycle; dw_run asserts next cycle.
- rst asserted at the 5th DW beat -> all outputs 0 next cycle; a new start replays from channel 0, (0,0).
- start pulsed during PW_RUN -> ignored; exactly one done.
- dw_res_valid held 1 in IDLE -> dw_res_ready=0, no fmw_en.

Source files
------------

// File: rtl/dw_pw_layer_sched_pkg.sv
// -----------------------------------------------------------------------------
// dw_pw_layer_sched_pkg
// Shared types and constants for the depthwise/pointwise layer scheduler.
//   sched_state_t     : scheduler FSM states
//   CH_W_DEF          : default channel index width
//   HW_W_DEF          : default row/column index width
//   LAYER_W_DEF       : default layer index width
//   LOAD_PULSE_CYCLES : length of the ld_start pulse issued from a LOAD state
// -----------------------------------------------------------------------------
package dw_pw_layer_sched_pkg;

   localparam int CH_W_DEF          = 10;
   localparam int HW_W_DEF          = 7;
   localparam int LAYER_W_DEF       = 5;
   localparam int LOAD_PULSE_CYCLES = 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DW_LOAD = 3'd1,
      ST_DW_WAIT = 3'd2,
      ST_DW_RUN  = 3'd3,
      ST_PW_LOAD = 3'd4,
      ST_PW_WAIT = 3'd5,
      ST_PW_RUN  = 3'd6,
      ST_FINISH  = 3'd7
   } sched_state_t;

endpackage

// File: rtl/sched_hw_counter.sv
// -----------------------------------------------------------------------------
// sched_hw_counter
// Nested (ch, h, w) index counter used for every address stream of the
// scheduler. Advances one step per cycle with en=1.
//   CH_FASTEST=1 : ch is the innermost index, then w, then h.
//   CH_FASTEST=0 : w innermost, then h, then ch (ch stays fixed over a plane).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear of all indices
//   en         : advance one step
//   ch, h, w   : current indices
//   ch_last    : ch is at N_CH-1
//   hw_last    : h and w are both at N_HW-1
// -----------------------------------------------------------------------------
module sched_hw_counter
   import dw_pw_layer_sched_pkg::*;
#(
   parameter int CH_W       = CH_W_DEF,
   parameter int HW_W       = HW_W_DEF,
   parameter int N_CH       = 16,
   parameter int N_HW       = 64,
   parameter bit CH_FASTEST = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   output logic [CH_W-1:0] ch,
   output logic [HW_W-1:0] h,
   output logic [HW_W-1:0] w,
   output logic            ch_last,
   output logic            hw_last
);

   if (N_CH < 1 || N_CH > (1 << CH_W)) begin : g_chk_ch
      $error("sched_hw_counter: CH_W too narrow for N_CH");
   end
   if (N_HW < 1 || N_HW > (1 << HW_W)) begin : g_chk_hw
      $error("sched_hw_counter: HW_W too narrow for N_HW");
   end

   logic            h_last;
   logic            w_last;
   logic [CH_W-1:0] ch_step;
   logic [HW_W-1:0] h_step;
   logic [HW_W-1:0] w_step;

   assign ch_last = (ch == CH_W'(N_CH - 1));
   assign h_last  = (h == HW_W'(N_HW - 1));
   assign w_last  = (w == HW_W'(N_HW - 1));
   assign hw_last = h_last & w_last;

   assign ch_step = ch_last ? '0 : ch + CH_W'(1);
   assign h_step  = h_last  ? '0 : h + HW_W'(1);
   assign w_step  = w_last  ? '0 : w + HW_W'(1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ch <= '0;
         h  <= '0;
         w  <= '0;
      end else if (en) begin
         if (CH_FASTEST) begin
            ch <= ch_step;
            if (ch_last) begin
               w <= w_step;
               if (w_last) h <= h_step;
            end
         end else begin
            w <= w_step;
            if (w_last) begin
               h <= h_step;
               if (h_last) ch <= ch_step;
            end
         end
      end
   end

endmodule

// File: rtl/dw_pw_layer_sched.sv
// -----------------------------------------------------------------------------
// dw_pw_layer_sched
// Sequencing controller for one depthwise-3x3 + pointwise-1x1 layer pair.
// Depthwise phase: per channel, load weights/bias, then stream relu33 results
// into the intermediate buffer (row-major per channel). Pointwise phase: per
// output channel, load weights/bias, issue intermediate reads (input channel
// fastest), and write each accumulated result row-major to the output.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   start / busy / done       : layer handshake (done is a 1-cycle pulse)
//   ld_start, ld_layer,
//   ld_in_ch, ld_out_ch,
//   ld_done                   : weight + bias/scale load handshake
//   dw_run, dw_res_valid,
//   dw_res_ready              : depthwise stream control
//   fmw_en, fmw_ch/h/w        : intermediate buffer write
//   pw_rd_valid/ready,
//   pw_rd_ch/h/w              : intermediate buffer read requests
//   pw_res_valid/ready        : pointwise result handshake
//   pw_wr_en, pw_wr_ch/h/w    : output feature-map write
//   stall_cnt                 : only with DW_PW_SCHED_PERF_EN defined; counts
//                               load-wait cycles and stalled read cycles
// -----------------------------------------------------------------------------
module dw_pw_layer_sched
   import dw_pw_layer_sched_pkg::*;
#(
   parameter int LAYER_DW_NUM = 1,
   parameter int LAYER_PW_NUM = 2,
   parameter int DW_CH        = 16,
   parameter int DW_OUT_HW    = 64,
   parameter int PW_IN_CH     = 16,
   parameter int PW_OUT_CH    = 32,
   parameter int CH_W         = CH_W_DEF,
   parameter int HW_W         = HW_W_DEF,
   parameter int LAYER_W      = LAYER_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               ld_start,
   output logic [LAYER_W-1:0] ld_layer,
   output logic [CH_W-1:0]    ld_in_ch,
   output logic [CH_W-1:0]    ld_out_ch,
   input  logic               ld_done,
   output logic               dw_run,
   input  logic               dw_res_valid,
   output logic               dw_res_ready,
   output logic               fmw_en,
   output logic [CH_W-1:0]    fmw_ch,
   output logic [HW_W-1:0]    fmw_h,
   output logic [HW_W-1:0]    fmw_w,
   output logic               pw_rd_valid,
   input  logic               pw_rd_ready,
   output logic [CH_W-1:0]    pw_rd_ch,
   output logic [HW_W-1:0]    pw_rd_h,
   output logic [HW_W-1:0]    pw_rd_w,
   input  logic               pw_res_valid,
   output logic               pw_res_ready,
   output logic               pw_wr_en,
   output logic [CH_W-1:0]    pw_wr_ch,
   output logic [HW_W-1:0]    pw_wr_h,
   output logic [HW_W-1:0]    pw_wr_w
`ifdef DW_PW_SCHED_PERF_EN
   ,output logic [31:0]       stall_cnt
`endif
);

   // Elaboration-time sanity checks on the configuration.
   if (PW_IN_CH != DW_CH) begin : g_chk_ch_eq
      $error("dw_pw_layer_sched: PW_IN_CH must equal DW_CH");
   end
   if (DW_CH > (1 << CH_W) || PW_OUT_CH > (1 << CH_W)) begin : g_chk_ch_w
      $error("dw_pw_layer_sched: CH_W too narrow for channel counts");
   end
   if (DW_OUT_HW > (1 << HW_W)) begin : g_chk_hw_w
      $error("dw_pw_layer_sched: HW_W too narrow for DW_OUT_HW");
   end
   if (LAYER_DW_NUM >= (1 << LAYER_W) || LAYER_PW_NUM >= (1 << LAYER_W)) begin : g_chk_layer_w
      $error("dw_pw_layer_sched: LAYER_W too narrow for layer numbers");
   end
   // The LOAD states are single-cycle, which only produces the intended pulse
   // length when it is one cycle.
   if (LOAD_PULSE_CYCLES != 1) begin : g_chk_pulse
      $error("dw_pw_layer_sched: LOAD states emit a single-cycle ld_start");
   end

   sched_state_t state;
   sched_state_t state_nxt;

   logic start_acc;
   logic dw_beat;
   logic rd_beat;
   logic res_beat;
   logic rd_issued;   // all reads for the current output channel are issued

   logic [CH_W-1:0] dw_c;
   logic [CH_W-1:0] oc;
   logic dw_ch_last, dw_hw_last;
   logic rd_ch_last, rd_hw_last;
   logic res_ch_last, res_hw_last;

   // ---------------------------------------------------------------------------
   // Handshakes and status, decoded from the registered state
   // ---------------------------------------------------------------------------
   assign start_acc    = (state == ST_IDLE) & start;
   assign busy         = (state != ST_IDLE) & (state != ST_FINISH);
   assign done         = (state == ST_FINISH);

   assign dw_run       = (state == ST_DW_RUN);
   assign dw_res_ready = dw_run;
   assign dw_beat      = dw_res_valid & dw_res_ready;
   assign fmw_en       = dw_beat;
   assign fmw_ch       = dw_c;

   assign pw_rd_valid  = (state == ST_PW_RUN) & ~rd_issued;
   assign rd_beat      = pw_rd_valid & pw_rd_ready;

   assign pw_res_ready = (state == ST_PW_RUN);
   assign res_beat     = pw_res_valid & pw_res_ready;
   assign pw_wr_en     = res_beat;
   assign pw_wr_ch     = oc;

   // ---------------------------------------------------------------------------
   // Address streams
   // ---------------------------------------------------------------------------
   // Depthwise write: channel held over a whole plane, then advances.
   sched_hw_counter #(
      .CH_W(CH_W), .HW_W(HW_W), .N_CH(DW_CH), .N_HW(DW_OUT_HW), .CH_FASTEST(1'b0)
   ) u_dw_wr (
      .clk(clk), .rst(rst), .clr(start_acc), .en(dw_beat),
      .ch(dw_c), .h(fmw_h), .w(fmw_w),
      .ch_last(dw_ch_last), .hw_last(dw_hw_last)
   );

   // Pointwise read: input channel fastest so the adder tree sees one pixel's
   // channels back to back. Restarted at every output-channel load.
   sched_hw_counter #(
      .CH_W(CH_W), .HW_W(HW_W), .N_CH(PW_IN_CH), .N_HW(DW_OUT_HW), .CH_FASTEST(1'b1)
   ) u_pw_rd (
      .clk(clk), .rst(rst), .clr(start_acc | (state == ST_PW_LOAD)), .en(rd_beat),
      .ch(pw_rd_ch), .h(pw_rd_h), .w(pw_rd_w),
      .ch_last(rd_ch_last), .hw_last(rd_hw_last)
   );

   // Pointwise result: its channel index is the current output channel.
   sched_hw_counter #(
      .CH_W(CH_W), .HW_W(HW_W), .N_CH(PW_OUT_CH), .N_HW(DW_OUT_HW), .CH_FASTEST(1'b0)
   ) u_pw_wr (
      .clk(clk), .rst(rst), .clr(start_acc), .en(res_beat),
      .ch(oc), .h(pw_wr_h), .w(pw_wr_w),
      .ch_last(res_ch_last), .hw_last(res_hw_last)
   );

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         rd_issued <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state != ST_PW_RUN) begin
            rd_issued <= 1'b0;
         end else if (rd_beat && rd_ch_last && rd_hw_last) begin
            rd_issued <= 1'b1;
         end
      end
   end

   // NOTE: every signal driven here is given a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      ld_start  = 1'b0;
      ld_layer  = '0;
      ld_in_ch  = '0;
      ld_out_ch = '0;

      unique case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_DW_LOAD;
         end

         ST_DW_LOAD: begin
            ld_start  = 1'b1;
            ld_layer  = LAYER_W'(LAYER_DW_NUM);
            ld_in_ch  = dw_c;
            ld_out_ch = dw_c;
            // A load that completes in the request cycle skips the wait.
            state_nxt = ld_done ? ST_DW_RUN : ST_DW_WAIT;
         end

         ST_DW_WAIT: begin
            ld_layer  = LAYER_W'(LAYER_DW_NUM);
            ld_in_ch  = dw_c;
            ld_out_ch = dw_c;
            if (ld_done) state_nxt = ST_DW_RUN;
         end

         ST_DW_RUN: begin
            if (dw_beat && dw_hw_last) begin
               state_nxt = dw_ch_last ? ST_PW_LOAD : ST_DW_LOAD;
            end
         end

         ST_PW_LOAD: begin
            ld_start  = 1'b1;
            ld_layer  = LAYER_W'(LAYER_PW_NUM);
            ld_out_ch = oc;
            state_nxt = ld_done ? ST_PW_RUN : ST_PW_WAIT;
         end

         ST_PW_WAIT: begin
            ld_layer  = LAYER_W'(LAYER_PW_NUM);
            ld_out_ch = oc;
            if (ld_done) state_nxt = ST_PW_RUN;
         end

         ST_PW_RUN: begin
            // The plane is complete once its last result is written, which
            // is necessarily after its last read was issued.
            if (res_beat && res_hw_last) begin
               state_nxt = res_ch_last ? ST_FINISH : ST_PW_LOAD;
            end
         end

         ST_FINISH: begin
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

`ifdef DW_PW_SCHED_PERF_EN
   // ---------------------------------------------------------------------------
   // Stall counter: load-wait cycles plus read requests blocked by the buffer.
   // ---------------------------------------------------------------------------
   logic stall_inc;

   assign stall_inc = (state == ST_DW_WAIT) | (state == ST_PW_WAIT) |
                      (pw_rd_valid & ~pw_rd_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (start_acc) begin
         stall_cnt <= '0;
      end else if (stall_inc && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dw_pw_layer_sched.sv
// -----------------------------------------------------------------------------
// tb_dw_pw_layer_sched
// Directed self-checking bench for dw_pw_layer_sched with a reduced geometry
// (2 DW channels, 4x4 planes, 2 PW input and 2 PW output channels). A small
// responder answers loads after a set latency and returns one pointwise
// result per PW_IN_CH accepted reads; observed streams are compared against
// sequences the bench builds from plain nested loops.
// -----------------------------------------------------------------------------
module tb_dw_pw_layer_sched;

   localparam int DW_CH     = 2;
   localparam int DW_OUT_HW = 4;
   localparam int PW_IN_CH  = 2;
   localparam int PW_OUT_CH = 2;
   localparam int CH_W      = 10;
   localparam int HW_W      = 7;
   localparam int LAYER_W   = 5;
   localparam int BUDGET    = 2000;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               busy;
   logic               done;
   logic               ld_start;
   logic [LAYER_W-1:0] ld_layer;
   logic [CH_W-1:0]    ld_in_ch;
   logic [CH_W-1:0]    ld_out_ch;
   logic               ld_done;
   logic               dw_run;
   logic               dw_res_valid;
   logic               dw_res_ready;
   logic               fmw_en;
   logic [CH_W-1:0]    fmw_ch;
   logic [HW_W-1:0]    fmw_h;
   logic [HW_W-1:0]    fmw_w;
   logic               pw_rd_valid;
   logic               pw_rd_ready;
   logic [CH_W-1:0]    pw_rd_ch;
   logic [HW_W-1:0]    pw_rd_h;
   logic [HW_W-1:0]    pw_rd_w;
   logic               pw_res_valid;
   logic               pw_res_ready;
   logic               pw_wr_en;
   logic [CH_W-1:0]    pw_wr_ch;
   logic [HW_W-1:0]    pw_wr_h;
   logic [HW_W-1:0]    pw_wr_w;
`ifdef DW_PW_SCHED_PERF_EN
   logic [31:0]        stall_cnt;
`endif

   logic [105:0] out_bus;
   assign out_bus = {busy, done, ld_start, ld_layer, ld_in_ch, ld_out_ch, dw_run,
                     dw_res_ready, fmw_en, fmw_ch, fmw_h, fmw_w, pw_rd_valid,
                     pw_rd_ch, pw_rd_h, pw_rd_w, pw_res_ready, pw_wr_en,
                     pw_wr_ch, pw_wr_h, pw_wr_w};

   int n_checks = 0;
   int n_fail   = 0;

   int ld_q[$];
   int fmw_q[$];
   int rd_q[$];
   int wr_q[$];
   int done_cnt;
   int stall_seen;

   always #5 clk = ~clk;

   dw_pw_layer_sched #(
      .LAYER_DW_NUM(1), .LAYER_PW_NUM(2),
      .DW_CH(DW_CH), .DW_OUT_HW(DW_OUT_HW), .PW_IN_CH(PW_IN_CH), .PW_OUT_CH(PW_OUT_CH),
      .CH_W(CH_W), .HW_W(HW_W), .LAYER_W(LAYER_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .ld_start(ld_start), .ld_layer(ld_layer), .ld_in_ch(ld_in_ch),
      .ld_out_ch(ld_out_ch), .ld_done(ld_done),
      .dw_run(dw_run), .dw_res_valid(dw_res_valid), .dw_res_ready(dw_res_ready),
      .fmw_en(fmw_en), .fmw_ch(fmw_ch), .fmw_h(fmw_h), .fmw_w(fmw_w),
      .pw_rd_valid(pw_rd_valid), .pw_rd_ready(pw_rd_ready),
      .pw_rd_ch(pw_rd_ch), .pw_rd_h(pw_rd_h), .pw_rd_w(pw_rd_w),
      .pw_res_valid(pw_res_valid), .pw_res_ready(pw_res_ready),
      .pw_wr_en(pw_wr_en), .pw_wr_ch(pw_wr_ch), .pw_wr_h(pw_wr_h), .pw_wr_w(pw_wr_w)
`ifdef DW_PW_SCHED_PERF_EN
      ,.stall_cnt(stall_cnt)
`endif
   );

   function automatic int pk(input int c, input int h, input int w);
      return (c << 16) | (h << 8) | w;
   endfunction

   function automatic int pk_ld(input int layer, input int ic, input int oc);
      return (layer << 24) | (ic << 12) | oc;
   endfunction

   // Advance to just after the next rising edge; inputs are driven here and
   // outputs are sampled a further #1 later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Runs one complete layer and compares every observed stream.
   //   ld_lat     : cycles from ld_start to ld_done (0 = same cycle)
   //   rdy_toggle : pw_rd_ready alternates 1,0,1,0...
   //   poke_start : pulse start once while pointwise results are accepted
   // ---------------------------------------------------------------------------
   task automatic run_layer(input int ld_lat, input bit rdy_toggle, input bit poke_start);
      int  cd;
      int  pend;
      int  rd_acc;
      int  post;
      int  idx;
      bit  rdy_ph;
      bit  poked;
      bit  prev_stall;
      bit  prev_ld_dw;
      bit  prev_ld_pw;
      logic [23:0] prev_rd;

      ld_q.delete(); fmw_q.delete(); rd_q.delete(); wr_q.delete();
      done_cnt = 0; stall_seen = 0;
      cd = 0; pend = 0; rd_acc = 0; post = 0;
      rdy_ph = 1'b1; poked = 1'b0; prev_stall = 1'b0;
      prev_ld_dw = 1'b0; prev_ld_pw = 1'b0; prev_rd = '0;

      start = 1'b1; dw_res_valid = 1'b1; ld_done = 1'b0;
      pw_res_valid = 1'b0; pw_rd_ready = 1'b1;
      tick();

      for (int cyc = 0; cyc < BUDGET; cyc++) begin
         // Drive this cycle's inputs from state-decoded outputs.
         start = 1'b0;
         if (poke_start && !poked && pw_res_ready) begin
            start = 1'b1;
            poked = 1'b1;
         end
         ld_done = 1'b0;
         if (ld_start) begin
            ld_q.push_back(pk_ld(int'(ld_layer), int'(ld_in_ch), int'(ld_out_ch)));
            if (ld_lat == 0) ld_done = 1'b1;
            else cd = ld_lat;
         end else if (cd > 0) begin
            cd--;
            if (cd == 0) ld_done = 1'b1;
         end
         pw_rd_ready  = rdy_toggle ? rdy_ph : 1'b1;
         rdy_ph       = ~rdy_ph;
         pw_res_valid = (pend > 0);

         if (ld_lat == 0 && prev_ld_dw) begin
            n_checks++;
            if (dw_run !== 1'b1) begin
               n_fail++;
               $display("FAIL same_cycle_dw_run: got %0b expected 1", dw_run);
            end
         end
         if (ld_lat == 0 && prev_ld_pw) begin
            n_checks++;
            if (pw_res_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL same_cycle_pw_run: got %0b expected 1", pw_res_ready);
            end
         end

         #1;
         prev_ld_dw = ld_start && (ld_layer == 5'd1);
         prev_ld_pw = ld_start && (ld_layer == 5'd2);

         if (prev_stall) begin
            n_checks++;
            if ({pw_rd_ch[7:0], pw_rd_h[7:0], pw_rd_w[7:0]} !== prev_rd) begin
               n_fail++;
               $display("FAIL rd_addr_hold: got %0h expected %0h",
                        {pw_rd_ch[7:0], pw_rd_h[7:0], pw_rd_w[7:0]}, prev_rd);
            end
         end
         prev_stall = pw_rd_valid && !pw_rd_ready;
         if (prev_stall) begin
            stall_seen++;
            prev_rd = {pw_rd_ch[7:0], pw_rd_h[7:0], pw_rd_w[7:0]};
         end

         if (fmw_en) fmw_q.push_back(pk(int'(fmw_ch), int'(fmw_h), int'(fmw_w)));
         if (pw_rd_valid && pw_rd_ready) begin
            rd_q.push_back(pk(int'(pw_rd_ch), int'(pw_rd_h), int'(pw_rd_w)));
            rd_acc++;
            if (rd_acc % PW_IN_CH == 0) pend++;
         end
         if (pw_wr_en) begin
            wr_q.push_back(pk(int'(pw_wr_ch), int'(pw_wr_h), int'(pw_wr_w)));
            pend--;
         end
         if (done) begin
            done_cnt++;
            n_checks++;
            if (busy !== 1'b0) begin
               n_fail++;
               $display("FAIL busy_at_done: got %0b expected 0", busy);
            end
         end
         if (done_cnt > 0) post++;
         if (post == 6) break;
         tick();
      end

      start = 1'b0; dw_res_valid = 1'b0; ld_done = 1'b0;
      pw_res_valid = 1'b0; pw_rd_ready = 1'b0;

      n_checks++;
      if (done_cnt != 1) begin
         n_fail++;
         $display("FAIL done_count: got %0d expected 1", done_cnt);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_after_done: got %0b expected 0", busy);
      end
      if (poke_start) begin
         n_checks++;
         if (!poked) begin
            n_fail++;
            $display("FAIL poke_issued: got 0 expected 1");
         end
      end

      // Load requests: DW channels 0..DW_CH-1, then PW output channels.
      n_checks++;
      if (ld_q.size() != DW_CH + PW_OUT_CH) begin
         n_fail++;
         $display("FAIL ld_count: got %0d expected %0d", ld_q.size(), DW_CH + PW_OUT_CH);
      end
      idx = 0;
      for (int c = 0; c < DW_CH + PW_OUT_CH; c++) begin
         int exp_ld;
         exp_ld = (c < DW_CH) ? pk_ld(1, c, c) : pk_ld(2, 0, c - DW_CH);
         if (c < ld_q.size()) begin
            n_checks++;
            if (ld_q[c] != exp_ld) begin
               n_fail++;
               $display("FAIL ld_seq[%0d]: got %0h expected %0h", c, ld_q[c], exp_ld);
            end
         end
      end

      // Intermediate writes: channel-major, then row-major.
      n_checks++;
      if (fmw_q.size() != DW_CH * DW_OUT_HW * DW_OUT_HW) begin
         n_fail++;
         $display("FAIL fmw_count: got %0d expected %0d", fmw_q.size(), DW_CH * DW_OUT_HW * DW_OUT_HW);
      end
      idx = 0;
      for (int c = 0; c < DW_CH; c++)
         for (int h = 0; h < DW_OUT_HW; h++)
            for (int w = 0; w < DW_OUT_HW; w++) begin
               if (idx < fmw_q.size()) begin
                  n_checks++;
                  if (fmw_q[idx] != pk(c, h, w)) begin
                     n_fail++;
                     $display("FAIL fmw_seq[%0d]: got %0h expected %0h", idx, fmw_q[idx], pk(c, h, w));
                  end
               end
               idx++;
            end

      // Reads: per output channel, h, then w, input channel fastest.
      n_checks++;
      if (rd_q.size() != PW_OUT_CH * DW_OUT_HW * DW_OUT_HW * PW_IN_CH) begin
         n_fail++;
         $display("FAIL rd_count: got %0d expected %0d", rd_q.size(),
                  PW_OUT_CH * DW_OUT_HW * DW_OUT_HW * PW_IN_CH);
      end
      idx = 0;
      for (int oc = 0; oc < PW_OUT_CH; oc++)
         for (int h = 0; h < DW_OUT_HW; h++)
            for (int w = 0; w < DW_OUT_HW; w++)
               for (int ic = 0; ic < PW_IN_CH; ic++) begin
                  if (idx < rd_q.size()) begin
                     n_checks++;
                     if (rd_q[idx] != pk(ic, h, w)) begin
                        n_fail++;
                        $display("FAIL rd_seq[%0d]: got %0h expected %0h", idx, rd_q[idx], pk(ic, h, w));
                     end
                  end
                  idx++;
               end

      // Output writes: per output channel, row-major.
      n_checks++;
      if (wr_q.size() != PW_OUT_CH * DW_OUT_HW * DW_OUT_HW) begin
         n_fail++;
         $display("FAIL wr_count: got %0d expected %0d", wr_q.size(), PW_OUT_CH * DW_OUT_HW * DW_OUT_HW);
      end
      idx = 0;
      for (int oc = 0; oc < PW_OUT_CH; oc++)
         for (int h = 0; h < DW_OUT_HW; h++)
            for (int w = 0; w < DW_OUT_HW; w++) begin
               if (idx < wr_q.size()) begin
                  n_checks++;
                  if (wr_q[idx] != pk(oc, h, w)) begin
                     n_fail++;
                     $display("FAIL wr_seq[%0d]: got %0h expected %0h", idx, wr_q[idx], pk(oc, h, w));
                  end
               end
               idx++;
            end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (out_bus !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %0h expected 0", out_bus);
      end
`ifdef DW_PW_SCHED_PERF_EN
      n_checks++;
      if (stall_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
      end
`endif
      rst = 1'b0;
      tick();
      n_checks++;
      if (out_bus !== '0) begin
         n_fail++;
         $display("FAIL idle_outputs: got %0h expected 0", out_bus);
      end
   endtask

   task automatic test_idle_ignore();
      dw_res_valid = 1'b1; pw_res_valid = 1'b1; ld_done = 1'b1; pw_rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if ({dw_res_ready, fmw_en, pw_res_ready, pw_wr_en, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: got %05b expected 00000",
                     {dw_res_ready, fmw_en, pw_res_ready, pw_wr_en, busy});
         end
      end
      dw_res_valid = 1'b0; pw_res_valid = 1'b0; ld_done = 1'b0; pw_rd_ready = 1'b0;
      tick();
   endtask

   task automatic test_nominal();
      run_layer(2, 1'b0, 1'b0);
`ifdef DW_PW_SCHED_PERF_EN
      // Two wait cycles per load, four loads, no read stalls.
      n_checks++;
      if (stall_cnt !== 32'd8) begin
         n_fail++;
         $display("FAIL nominal_stall_cnt: got %0d expected 8", stall_cnt);
      end
`endif
   endtask

   task automatic test_ready_toggle();
      run_layer(2, 1'b1, 1'b0);
      n_checks++;
      if (stall_seen == 0) begin
         n_fail++;
         $display("FAIL toggle_stalls_seen: got 0 expected nonzero");
      end
`ifdef DW_PW_SCHED_PERF_EN
      n_checks++;
      if (stall_cnt !== 32'(2 * (DW_CH + PW_OUT_CH) + stall_seen)) begin
         n_fail++;
         $display("FAIL toggle_stall_cnt: got %0d expected %0d", stall_cnt,
                  2 * (DW_CH + PW_OUT_CH) + stall_seen);
      end
      tick(); tick();
      n_checks++;
      if (stall_cnt !== 32'(2 * (DW_CH + PW_OUT_CH) + stall_seen)) begin
         n_fail++;
         $display("FAIL stall_cnt_hold: got %0d expected %0d", stall_cnt,
                  2 * (DW_CH + PW_OUT_CH) + stall_seen);
      end
`endif
   endtask

   task automatic test_same_cycle_ld();
      run_layer(0, 1'b0, 1'b0);
`ifdef DW_PW_SCHED_PERF_EN
      n_checks++;
      if (stall_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL same_cycle_stall_cnt: got %0d expected 0", stall_cnt);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int beats;
      int fifth;
      bit hit;
      beats = 0; fifth = -1; hit = 1'b0;
      start = 1'b1; dw_res_valid = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         ld_done = ld_start;
         #1;
         if (fmw_en) begin
            beats++;
            if (beats == 5) begin
               fifth = pk(int'(fmw_ch), int'(fmw_h), int'(fmw_w));
               rst   = 1'b1;
               hit   = 1'b1;
               break;
            end
         end
         tick();
      end
      n_checks++;
      if (!hit) begin
         n_fail++;
         $display("FAIL abort_reached: got 0 expected 1");
      end
      n_checks++;
      if (fifth != pk(0, 1, 0)) begin
         n_fail++;
         $display("FAIL fifth_beat_addr: got %0h expected %0h", fifth, pk(0, 1, 0));
      end
      ld_done = 1'b0;
      tick();
      n_checks++;
      if (out_bus !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got %0h expected 0", out_bus);
      end
      rst = 1'b0;
      dw_res_valid = 1'b0;
      tick();
      run_layer(2, 1'b0, 1'b0);
   endtask

   task automatic test_start_during_pw();
      run_layer(2, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ld_done = 1'b0; dw_res_valid = 1'b0;
      pw_rd_ready = 1'b0; pw_res_valid = 1'b0;
      test_reset();
      test_idle_ignore();
      test_nominal();
      test_ready_toggle();
      test_same_cycle_ld();
      test_reset_mid();
      test_start_during_pw();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
